election_controller_param: RTL and testbench
============================================

Name: election_controller_param

Overview:
- Parametrised, next-generation ballot controller for the avatar-selection system.
- Runs three clock-counted phases: registration, voting, then a sequential tally that publishes the winner.
- Generalises the fixed 4-box, 16-voter, 4-candidate, 100/100-cycle scheme.
- Adds a request-valid qualifier, asynchronous reset, candidate range checking, a sequential tally with tie detection, and a phase indicator.

Parameters:
- NUM_BOXES, 4, number of ballot boxes; power of two, ≥ 2.
- VOTERS_PER_BOX, 16, voters per box; power of two, ≥ 2.
- NUM_CANDIDATES, 4, number of candidates; 2..16, need not be a power of two.
- REG_CYCLES, 100, length of the registration phase in clocks.
- VOTE_CYCLES, 100, length of the voting phase in clocks.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- req_valid  in  1  qualifies mode/userID/candidate this cycle.
- mode  in  1  0 = register request, 1 = vote request.
- userID  in  BB+VB  upper BB bits = box, lower VB bits = voter index. BB = clog2(NUM_BOXES), VB = clog2(VOTERS_PER_BOX).
- candidate  in  CB  candidate index. CB = max(1, clog2(NUM_CANDIDATES)).
- ballotBoxId  out  BB  box field of the last accepted request.
- numberOfRegisteredVoters  out  CW  total registrations. CW = clog2(NUM_BOXES*VOTERS_PER_BOX+1).
- numberOfVotesWinner  out  CW  vote count of the winner; valid when ResultValid = 1.
- WinnerId  out  CB  winning candidate; valid when ResultValid = 1.
- Tie  out  1  more than one candidate holds the maximum; valid when ResultValid = 1.
- ResultValid  out  1  tally complete; stays high until reset.
- phase  out  2  current phase, encoded per the package.
- AlreadyRegistered, AlreadyVoted, NotRegistered, VotingHasNotStarted, RegistrationHasEnded, VotingHasEnded, InvalidCandidate  out  1 each  status flags; one-cycle pulses.

Behaviour:
- Reset (async, RST_N = 0):
  - Cleared: cycle counter, registered bitmap, voted bitmap, all per-candidate counters, tally registers.
  - All outputs go to 0; phase = PH_REG.
  - Reset asserted mid-phase or mid-tally aborts the election completely; no state is retained.
- Cycle counter cyc:
  - Increments on every posedge, independent of req_valid.
  - Saturates at REG_CYCLES+VOTE_CYCLES.
- Phase decision: the phase applied to a request is taken from cyc before the increment at that posedge.
  - cyc < REG_CYCLES → PH_REG.
  - cyc < REG_CYCLES+VOTE_CYCLES → PH_VOTE.
  - Otherwise → PH_TALLY, then PH_DONE.
- Request timing:
  - All outputs are registered; a request's response appears 1 cycle after the sampling edge.
  - Flags are cleared on every edge, then set by that cycle's request only.
  - With req_valid = 0: flags stay 0, no state changes, ballotBoxId holds its value.
- PH_REG request:
  - mode = 1 → VotingHasNotStarted.
  - mode = 0, voter unregistered → set registered bit, increment numberOfRegisteredVoters.
  - mode = 0, voter already registered → AlreadyRegistered.
  - ballotBoxId updates on any valid request.
- PH_VOTE request (ballotBoxId updates on any valid request). Checks are applied in this priority:
  1. mode = 0 → RegistrationHasEnded.
  2. Voter not registered → NotRegistered.
  3. Voter already voted → AlreadyVoted.
  4. candidate ≥ NUM_CANDIDATES → InvalidCandidate; voted bit is NOT set.
  5. Otherwise → increment that candidate's counter and set the voted bit.
- Counter width: candidate counters are CW wide and saturate at all-ones. They cannot overflow in legal use; saturation is a defensive rule.
- PH_TALLY:
  - Entered when cyc first reaches its terminal value.
  - Scans one candidate per cycle, indices 0..NUM_CANDIDATES-1, so the scan takes NUM_CANDIDATES cycles.
  - Strict greater-than updates max and WinnerId, so the lowest index wins a tie.
  - Equality with a nonzero max sets a tie marker; a strict update clears it.
  - All-zero votes: WinnerId = 0, count 0, Tie = 1.
- PH_DONE:
  - Entered after the last scan cycle.
  - ResultValid, WinnerId, numberOfVotesWinner and Tie are registered and then held until reset.
- Requests in PH_TALLY or PH_DONE → VotingHasEnded; no state change.

Decomposition:
- Package election_pkg:
  - Phase encoding: PH_REG = 0, PH_VOTE = 1, PH_TALLY = 2, PH_DONE = 3.
  - Mode constants: MODE_REG = 0, MODE_VOTE = 1.
  - clog2 width helper function.
- Sub-module tally_scanner:
  - Sequential max/tie scanner over the counter array.
  - Handshake: start pulse in; done pulse out, plus winner, count and tie.

Test Plan (default parameters):
- Reset mid-registration:
  - Stimulus: register IDs 0x05 and 0x25, assert RST_N = 0 for 1 cycle, then register 0x05.
  - Response: numberOfRegisteredVoters = 1; AlreadyRegistered = 0.
- Registration-phase errors:
  - Stimulus: register 0x13 twice; send a vote request at cyc = 10.
  - Response: second register → AlreadyRegistered; count stays 1; vote request → VotingHasNotStarted.
- Phase boundary:
  - Stimulus: register request sampled with cyc = 99, then another sampled with cyc = 100.
  - Response: first is accepted; second → RegistrationHasEnded.
- Voting errors:
  - Stimulus: vote with 0x13 for candidate 2 twice; vote with unregistered 0x30.
  - Response: second vote → AlreadyVoted; 0x30 → NotRegistered.
- Invalid candidate (NUM_CANDIDATES = 3):
  - Stimulus: vote with candidate = 3, then with candidate = 1.
  - Response: InvalidCandidate on the first; second accepted.
- Tally with tie:
  - Stimulus: votes of 3, 5, 5, 1 for candidates 0..3.
  - Response: ResultValid rises at cyc = 200 + 4 + 1; WinnerId = 1, numberOfVotesWinner = 5, Tie = 1; a later request → VotingHasEnded.

Source files
------------

// File: rtl/election_pkg.sv
// Shared definitions for the parametrised election controller.
// - Phase encoding used on the phase output and for request decoding.
// - Request mode constants.
// - Packed status-flag bundle (one-cycle pulses).
// - Ceiling-log2 helper for deriving port widths from parameters.
package election_pkg;

  localparam logic [1:0] PH_REG   = 2'd0;
  localparam logic [1:0] PH_VOTE  = 2'd1;
  localparam logic [1:0] PH_TALLY = 2'd2;
  localparam logic [1:0] PH_DONE  = 2'd3;

  localparam logic MODE_REG  = 1'b0;
  localparam logic MODE_VOTE = 1'b1;

  typedef struct packed {
    logic already_registered;
    logic already_voted;
    logic not_registered;
    logic voting_not_started;
    logic registration_ended;
    logic voting_ended;
    logic invalid_candidate;
  } flags_t;

  // Ceiling log2; calc_clog2(1) = 0.
  function automatic int calc_clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/tally_scanner.sv
// Sequential max/tie scanner over the per-candidate vote counters.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - one-cycle pulse that begins a scan
//   cnt_flat    - counters packed as {cnt[N-1], ..., cnt[0]}, CW bits each
//   done        - one-cycle pulse, winner/max_cnt/tie valid from then on
//   winner      - lowest index holding the maximum count
//   max_cnt     - maximum count
//   tie         - more than one candidate holds the maximum, or all zero
//
// Handshake: start is a one-cycle request that is always accepted when the
// scanner is idle (it is ignored while a scan is running); done is a one-cycle
// response that follows exactly NUM_CANDIDATES cycles after start is sampled,
// and the result outputs hold until the next start.
module tally_scanner #(
  parameter int NUM_CANDIDATES = 4,
  parameter int CW             = 7,
  parameter int CB             = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [NUM_CANDIDATES*CW-1:0] cnt_flat,
  output logic                         done,
  output logic [CB-1:0]                winner,
  output logic [CW-1:0]                max_cnt,
  output logic                         tie
);

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tie_q, tie_d;
  logic [CB-1:0] idx_q, idx_d;
  logic [CB-1:0] win_q, win_d;
  logic [CW-1:0] max_q, max_d;

  logic [CB-1:0] sel_idx;
  logic [CW-1:0] cur_cnt;
  logic          last_idx;

  // The start cycle already evaluates index 0, so the scan is N cycles long.
  assign sel_idx  = busy_q ? idx_q : '0;
  assign last_idx = (32'(sel_idx) == NUM_CANDIDATES - 1);

  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < NUM_CANDIDATES; i++) begin
      if (32'(sel_idx) == i) cur_cnt = cnt_flat[i*CW +: CW];
    end
  end

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    tie_d  = tie_q;
    idx_d  = idx_q;
    win_d  = win_q;
    max_d  = max_q;
    if (start && !busy_q) begin
      // Index 0 against an empty maximum always becomes the running winner.
      max_d  = cur_cnt;
      win_d  = '0;
      tie_d  = 1'b0;
      idx_d  = CB'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cur_cnt > max_q) begin
        max_d = cur_cnt;
        win_d = idx_q;
        tie_d = 1'b0;
      end else if ((cur_cnt == max_q) && (max_q != '0)) begin
        tie_d = 1'b1;
      end
      if (last_idx) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      tie_q  <= 1'b0;
      idx_q  <= '0;
      win_q  <= '0;
      max_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      tie_q  <= tie_d;
      idx_q  <= idx_d;
      win_q  <= win_d;
      max_q  <= max_d;
    end
  end

  assign done    = done_q;
  assign winner  = win_q;
  assign max_cnt = max_q;
  // An all-zero election has every candidate at the maximum.
  assign tie     = tie_q || (max_q == '0);

endmodule

// File: rtl/election_controller_param.sv
// Parametrised ballot controller: clock-counted registration and voting
// phases followed by a sequential tally that publishes the winner.
// Ports:
//   CLK, RST_N                 - clock, asynchronous active-low reset
//   req_valid, mode, userID,   - request (mode 0 register, 1 vote); userID is
//   candidate                    {box, voter}
//   ballotBoxId                - box field of the last accepted request
//   numberOfRegisteredVoters   - total registrations
//   numberOfVotesWinner,       - tally result, valid while ResultValid = 1
//   WinnerId, Tie
//   ResultValid                - tally complete, held until reset
//   phase                      - current phase (debug view of the phase FSM)
//   AlreadyRegistered ... InvalidCandidate - one-cycle status pulses
module election_controller_param
  import election_pkg::*;
#(
  parameter int NUM_BOXES      = 4,
  parameter int VOTERS_PER_BOX = 16,
  parameter int NUM_CANDIDATES = 4,
  parameter int REG_CYCLES     = 100,
  parameter int VOTE_CYCLES    = 100,
  localparam int BB         = calc_clog2(NUM_BOXES),
  localparam int VB         = calc_clog2(VOTERS_PER_BOX),
  localparam int UW         = BB + VB,
  localparam int CB         = (calc_clog2(NUM_CANDIDATES) < 1) ? 1 : calc_clog2(NUM_CANDIDATES),
  localparam int NUM_VOTERS = NUM_BOXES * VOTERS_PER_BOX,
  localparam int CW         = calc_clog2(NUM_VOTERS + 1)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          req_valid,
  input  logic          mode,
  input  logic [UW-1:0] userID,
  input  logic [CB-1:0] candidate,
  output logic [BB-1:0] ballotBoxId,
  output logic [CW-1:0] numberOfRegisteredVoters,
  output logic [CW-1:0] numberOfVotesWinner,
  output logic [CB-1:0] WinnerId,
  output logic          Tie,
  output logic          ResultValid,
  output logic [1:0]    phase,
  output logic          AlreadyRegistered,
  output logic          AlreadyVoted,
  output logic          NotRegistered,
  output logic          VotingHasNotStarted,
  output logic          RegistrationHasEnded,
  output logic          VotingHasEnded,
  output logic          InvalidCandidate
);

  localparam int TOTAL_CYCLES = REG_CYCLES + VOTE_CYCLES;
  localparam int YW           = calc_clog2(TOTAL_CYCLES + 1);
  localparam logic [YW-1:0] REG_END = YW'(REG_CYCLES);
  localparam logic [YW-1:0] TOT_END = YW'(TOTAL_CYCLES);

  logic [YW-1:0]         cyc_q, cyc_d;
  logic [NUM_VOTERS-1:0] reg_bm_q, reg_bm_d;
  logic [NUM_VOTERS-1:0] voted_bm_q, voted_bm_d;
  logic [CW-1:0]         cand_cnt_q [NUM_CANDIDATES];
  logic [CW-1:0]         cand_cnt_d [NUM_CANDIDATES];
  logic [CW-1:0]         nreg_q, nreg_d;
  logic [BB-1:0]         box_q, box_d;
  flags_t                flags_q, flags_d;
  logic                  tally_started_q, tally_started_d;
  logic                  res_valid_q, res_valid_d;
  logic [CB-1:0]         winner_q, winner_d;
  logic [CW-1:0]         win_cnt_q, win_cnt_d;
  logic                  tie_q, tie_d;
  logic [1:0]            phase_q, phase_d;

  logic [1:0]                   req_phase;
  logic                         cand_ok;
  logic                         tally_start;
  logic [NUM_CANDIDATES*CW-1:0] cnt_flat;
  logic                         scan_done;
  logic [CB-1:0]                scan_winner;
  logic [CW-1:0]                scan_max;
  logic                         scan_tie;

  for (genvar g = 0; g < NUM_CANDIDATES; g++) begin : g_flat
    assign cnt_flat[g*CW +: CW] = cand_cnt_q[g];
  end

  // Requests are classified by the counter value before this edge's increment.
  assign req_phase = (cyc_q < REG_END) ? PH_REG :
                     (cyc_q < TOT_END) ? PH_VOTE : PH_TALLY;
  assign cand_ok   = (32'(candidate) < NUM_CANDIDATES);

  always_comb begin
    flags_d    = '0;
    reg_bm_d   = reg_bm_q;
    voted_bm_d = voted_bm_q;
    cand_cnt_d = cand_cnt_q;
    nreg_d     = nreg_q;
    box_d      = box_q;
    if (req_valid) begin
      case (req_phase)
        PH_REG: begin
          box_d = userID[UW-1:VB];
          if (mode == MODE_VOTE) begin
            flags_d.voting_not_started = 1'b1;
          end else if (reg_bm_q[userID]) begin
            flags_d.already_registered = 1'b1;
          end else begin
            reg_bm_d[userID] = 1'b1;
            nreg_d           = nreg_q + 1'b1;
          end
        end
        PH_VOTE: begin
          box_d = userID[UW-1:VB];
          if (mode == MODE_REG) begin
            flags_d.registration_ended = 1'b1;
          end else if (!reg_bm_q[userID]) begin
            flags_d.not_registered = 1'b1;
          end else if (voted_bm_q[userID]) begin
            flags_d.already_voted = 1'b1;
          end else if (!cand_ok) begin
            // Rejected ballot leaves the voter free to vote again.
            flags_d.invalid_candidate = 1'b1;
          end else begin
            voted_bm_d[userID] = 1'b1;
            for (int i = 0; i < NUM_CANDIDATES; i++) begin
              if ((32'(candidate) == i) && (cand_cnt_q[i] != '1)) begin
                cand_cnt_d[i] = cand_cnt_q[i] + 1'b1;
              end
            end
          end
        end
        default: flags_d.voting_ended = 1'b1;
      endcase
    end
  end

  // Cycle counter, tally launch, result capture and phase tracking.
  assign tally_start = (cyc_q == TOT_END) && !tally_started_q;

  always_comb begin
    cyc_d           = (cyc_q == TOT_END) ? cyc_q : cyc_q + 1'b1;
    tally_started_d = tally_started_q | tally_start;
    res_valid_d     = res_valid_q;
    winner_d        = winner_q;
    win_cnt_d       = win_cnt_q;
    tie_d           = tie_q;
    if (scan_done && !res_valid_q) begin
      res_valid_d = 1'b1;
      winner_d    = scan_winner;
      win_cnt_d   = scan_max;
      tie_d       = scan_tie;
    end
    if (cyc_d < REG_END)      phase_d = PH_REG;
    else if (cyc_d < TOT_END) phase_d = PH_VOTE;
    else if (res_valid_d)     phase_d = PH_DONE;
    else                      phase_d = PH_TALLY;
  end

  tally_scanner #(
    .NUM_CANDIDATES(NUM_CANDIDATES),
    .CW            (CW),
    .CB            (CB)
  ) u_scanner (
    .clk     (CLK),
    .rst_n   (RST_N),
    .start   (tally_start),
    .cnt_flat(cnt_flat),
    .done    (scan_done),
    .winner  (scan_winner),
    .max_cnt (scan_max),
    .tie     (scan_tie)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cyc_q           <= '0;
      reg_bm_q        <= '0;
      voted_bm_q      <= '0;
      for (int i = 0; i < NUM_CANDIDATES; i++) cand_cnt_q[i] <= '0;
      nreg_q          <= '0;
      box_q           <= '0;
      flags_q         <= '0;
      tally_started_q <= 1'b0;
      res_valid_q     <= 1'b0;
      winner_q        <= '0;
      win_cnt_q       <= '0;
      tie_q           <= 1'b0;
      phase_q         <= PH_REG;
    end else begin
      cyc_q           <= cyc_d;
      reg_bm_q        <= reg_bm_d;
      voted_bm_q      <= voted_bm_d;
      cand_cnt_q      <= cand_cnt_d;
      nreg_q          <= nreg_d;
      box_q           <= box_d;
      flags_q         <= flags_d;
      tally_started_q <= tally_started_d;
      res_valid_q     <= res_valid_d;
      winner_q        <= winner_d;
      win_cnt_q       <= win_cnt_d;
      tie_q           <= tie_d;
      phase_q         <= phase_d;
    end
  end

  assign ballotBoxId              = box_q;
  assign numberOfRegisteredVoters = nreg_q;
  assign numberOfVotesWinner      = win_cnt_q;
  assign WinnerId                 = winner_q;
  assign Tie                      = tie_q;
  assign ResultValid              = res_valid_q;
  assign phase                    = phase_q;
  assign AlreadyRegistered        = flags_q.already_registered;
  assign AlreadyVoted             = flags_q.already_voted;
  assign NotRegistered            = flags_q.not_registered;
  assign VotingHasNotStarted      = flags_q.voting_not_started;
  assign RegistrationHasEnded     = flags_q.registration_ended;
  assign VotingHasEnded           = flags_q.voting_ended;
  assign InvalidCandidate         = flags_q.invalid_candidate;

endmodule

// File: tb/tb_election_controller_param.sv
// Testbench for election_controller_param: a default-parameter instance and
// a small 3-candidate instance with short phases share one input bus.
module tb_election_controller_param;

  localparam logic [6:0] F_AR  = 7'b1000000;
  localparam logic [6:0] F_AV  = 7'b0100000;
  localparam logic [6:0] F_NR  = 7'b0010000;
  localparam logic [6:0] F_VNS = 7'b0001000;
  localparam logic [6:0] F_RHE = 7'b0000100;
  localparam logic [6:0] F_VHE = 7'b0000010;
  localparam logic [6:0] F_IC  = 7'b0000001;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       req_valid;
  logic       mode;
  logic [5:0] userID;
  logic [1:0] candidate;

  logic [1:0] box_a;
  logic [6:0] nreg_a, wcnt_a;
  logic [1:0] win_a;
  logic       tie_a, rv_a;
  logic [1:0] phase_a;
  logic       ar_a, av_a, nr_a, vns_a, rhe_a, vhe_a, ic_a;
  logic [6:0] flags_a;

  logic [1:0] box_b;
  logic [6:0] nreg_b, wcnt_b;
  logic [1:0] win_b;
  logic       tie_b, rv_b;
  logic [1:0] phase_b;
  logic       ar_b, av_b, nr_b, vns_b, rhe_b, vhe_b, ic_b;
  logic [6:0] flags_b;

  assign flags_a = {ar_a, av_a, nr_a, vns_a, rhe_a, vhe_a, ic_a};
  assign flags_b = {ar_b, av_b, nr_b, vns_b, rhe_b, vhe_b, ic_b};

  election_controller_param dut (
    .CLK(clk), .RST_N(rst_n), .req_valid(req_valid), .mode(mode),
    .userID(userID), .candidate(candidate),
    .ballotBoxId(box_a), .numberOfRegisteredVoters(nreg_a),
    .numberOfVotesWinner(wcnt_a), .WinnerId(win_a), .Tie(tie_a),
    .ResultValid(rv_a), .phase(phase_a),
    .AlreadyRegistered(ar_a), .AlreadyVoted(av_a), .NotRegistered(nr_a),
    .VotingHasNotStarted(vns_a), .RegistrationHasEnded(rhe_a),
    .VotingHasEnded(vhe_a), .InvalidCandidate(ic_a)
  );

  election_controller_param #(
    .NUM_CANDIDATES(3), .REG_CYCLES(8), .VOTE_CYCLES(8)
  ) dut_c3 (
    .CLK(clk), .RST_N(rst_n), .req_valid(req_valid), .mode(mode),
    .userID(userID), .candidate(candidate),
    .ballotBoxId(box_b), .numberOfRegisteredVoters(nreg_b),
    .numberOfVotesWinner(wcnt_b), .WinnerId(win_b), .Tie(tie_b),
    .ResultValid(rv_b), .phase(phase_b),
    .AlreadyRegistered(ar_b), .AlreadyVoted(av_b), .NotRegistered(nr_b),
    .VotingHasNotStarted(vns_b), .RegistrationHasEnded(rhe_b),
    .VotingHasEnded(vhe_b), .InvalidCandidate(ic_b)
  );

  // ---------------- scoreboard ----------------
  int n_cmp;
  int n_fail;
  int tb_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cyc %0d): got 0x%0h expected 0x%0h", name, tb_cyc, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One request sampled at the next posedge; tb_cyc counts edges since reset.
  task automatic step(input logic v, input logic m, input logic [5:0] uid, input logic [1:0] cand);
    @(negedge clk);
    req_valid = v;
    mode      = m;
    userID    = uid;
    candidate = cand;
    @(posedge clk);
    #1;
    tb_cyc++;
  endtask

  task automatic idle_until(input int c);
    while (tb_cyc < c) step(1'b0, 1'b0, 6'h00, 2'd0);
  endtask

  // Reset held across one posedge; reset values checked while asserted.
  task automatic do_reset();
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    check("rst_nreg_a",  32'(nreg_a), 32'd0);
    check("rst_box_a",   32'(box_a), 32'd0);
    check("rst_flags_a", 32'(flags_a), 32'd0);
    check("rst_rv_a",    32'(rv_a), 32'd0);
    check("rst_win_a",   32'(win_a), 32'd0);
    check("rst_phase_a", 32'(phase_a), 32'd0);
    check("rst_rv_b",    32'(rv_b), 32'd0);
    check("rst_tie_b",   32'(tie_b), 32'd0);
    rst_n  = 1'b1;
    tb_cyc = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       v;
    logic       m;
    logic [5:0] uid;
    logic [1:0] cand;
    logic [6:0] flags;
    logic [6:0] nreg;
    logic [1:0] box;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic m, input logic [5:0] uid,
                              input logic [1:0] cand, input logic [6:0] flags,
                              input logic [6:0] nreg, input logic [1:0] box);
    vec_t r;
    r.v = v; r.m = m; r.uid = uid; r.cand = cand;
    r.flags = flags; r.nreg = nreg; r.box = box;
    return r;
  endfunction

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(vecs[i].v, vecs[i].m, vecs[i].uid, vecs[i].cand);
      check($sformatf("vec%0d_flags", i), 32'(flags_a), 32'(vecs[i].flags));
      check($sformatf("vec%0d_nreg", i),  32'(nreg_a),  32'(vecs[i].nreg));
      check($sformatf("vec%0d_box", i),   32'(box_a),   32'(vecs[i].box));
    end
  endtask

  logic [5:0] reg_ids [11];

  initial begin
    n_cmp = 0; n_fail = 0; tb_cyc = 0;
    rst_n = 1'b0; req_valid = 1'b0; mode = 1'b0; userID = '0; candidate = '0;

    // Registration errors (cyc 1..4)
    vecs.push_back(mk(1, 0, 6'h13, 0, 7'd0, 7'd2, 2'd1));
    vecs.push_back(mk(1, 0, 6'h13, 0, F_AR, 7'd2, 2'd1));
    vecs.push_back(mk(0, 1, 6'h3F, 3, 7'd0, 7'd2, 2'd1));
    vecs.push_back(mk(1, 0, 6'h2A, 0, 7'd0, 7'd3, 2'd2));
    // Voting-phase errors and check priority (indices 4..9)
    vecs.push_back(mk(1, 1, 6'h13, 2, 7'd0,  7'd15, 2'd1));
    vecs.push_back(mk(1, 1, 6'h13, 2, F_AV,  7'd15, 2'd1));
    vecs.push_back(mk(1, 1, 6'h30, 1, F_NR,  7'd15, 2'd3));
    vecs.push_back(mk(1, 1, 6'h0D, 0, F_NR,  7'd15, 2'd0));
    vecs.push_back(mk(1, 0, 6'h05, 0, F_RHE, 7'd15, 2'd0));
    vecs.push_back(mk(1, 0, 6'h30, 0, F_RHE, 7'd15, 2'd3));
    // Accepted votes: cand0 x3, cand1 x5, cand2 x4 (+0x13), cand3 x1 (10..22)
    vecs.push_back(mk(1, 1, 6'h05, 0, 7'd0, 7'd15, 2'd0));
    vecs.push_back(mk(1, 1, 6'h20, 0, 7'd0, 7'd15, 2'd2));
    vecs.push_back(mk(1, 1, 6'h21, 0, 7'd0, 7'd15, 2'd2));
    vecs.push_back(mk(1, 1, 6'h22, 1, 7'd0, 7'd15, 2'd2));
    vecs.push_back(mk(1, 1, 6'h23, 1, 7'd0, 7'd15, 2'd2));
    vecs.push_back(mk(1, 1, 6'h24, 1, 7'd0, 7'd15, 2'd2));
    vecs.push_back(mk(1, 1, 6'h25, 1, 7'd0, 7'd15, 2'd2));
    vecs.push_back(mk(1, 1, 6'h26, 1, 7'd0, 7'd15, 2'd2));
    vecs.push_back(mk(1, 1, 6'h27, 2, 7'd0, 7'd15, 2'd2));
    vecs.push_back(mk(1, 1, 6'h28, 2, 7'd0, 7'd15, 2'd2));
    vecs.push_back(mk(1, 1, 6'h2A, 2, 7'd0, 7'd15, 2'd2));
    vecs.push_back(mk(1, 1, 6'h0A, 2, 7'd0, 7'd15, 2'd0));
    vecs.push_back(mk(1, 1, 6'h0B, 3, 7'd0, 7'd15, 2'd0));

    reg_ids = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h28, 6'h0A, 6'h0B};

    #12;
    check("init_nreg",  32'(nreg_a), 32'd0);
    check("init_phase", 32'(phase_a), 32'd0);
    do_reset();

    // Reset mid-registration discards earlier registrations
    step(1, 0, 6'h05, 0);
    check("pre_nreg1", 32'(nreg_a), 32'd1);
    step(1, 0, 6'h25, 0);
    check("pre_nreg2", 32'(nreg_a), 32'd2);
    check("pre_box2",  32'(box_a), 32'd2);
    do_reset();
    step(1, 0, 6'h05, 0);
    check("post_rst_nreg", 32'(nreg_a), 32'd1);
    check("post_rst_ar",   32'(ar_a), 32'd0);

    apply_vecs(0, 3);

    idle_until(10);
    step(1, 1, 6'h05, 0);
    check("vote_in_reg_flags", 32'(flags_a), 32'(F_VNS));
    check("vote_in_reg_nreg",  32'(nreg_a), 32'd3);
    check("vote_in_reg_box",   32'(box_a), 32'd0);
    step(0, 0, 6'h00, 0);
    check("flag_clears", 32'(flags_a), 32'd0);

    for (int k = 0; k < 11; k++) begin
      step(1, 0, reg_ids[k], 0);
      check($sformatf("reg%0d_nreg", k), 32'(nreg_a), 32'(4 + k));
      check($sformatf("reg%0d_box", k),  32'(box_a), 32'(reg_ids[k] >> 4));
    end

    // Phase boundary: cyc 99 still registers, cyc 100 is voting
    idle_until(99);
    check("phase_reg_99", 32'(phase_a), 32'd0);
    step(1, 0, 6'h0C, 0);
    check("bnd99_flags", 32'(flags_a), 32'd0);
    check("bnd99_nreg",  32'(nreg_a), 32'd15);
    check("phase_vote",  32'(phase_a), 32'd1);
    step(1, 0, 6'h0D, 0);
    check("bnd100_flags", 32'(flags_a), 32'(F_RHE));
    check("bnd100_nreg",  32'(nreg_a), 32'd15);

    apply_vecs(4, 22);

    // Tally: votes 3,5,5,1 -> winner 1, count 5, tie
    idle_until(199);
    check("phase_vote_199", 32'(phase_a), 32'd1);
    step(0, 0, 6'h00, 0);
    check("phase_tally", 32'(phase_a), 32'd2);
    idle_until(204);
    check("rv_204", 32'(rv_a), 32'd0);
    step(0, 0, 6'h00, 0);
    check("rv_205",    32'(rv_a), 32'd1);
    check("win_205",   32'(win_a), 32'd1);
    check("wcnt_205",  32'(wcnt_a), 32'd5);
    check("tie_205",   32'(tie_a), 32'd1);
    check("phase_done", 32'(phase_a), 32'd3);
    step(1, 1, 6'h0B, 3);
    check("late_vote_flags", 32'(flags_a), 32'(F_VHE));
    step(1, 0, 6'h3F, 0);
    check("late_reg_flags", 32'(flags_a), 32'(F_VHE));
    check("late_reg_nreg",  32'(nreg_a), 32'd15);
    check("late_reg_box",   32'(box_a), 32'd0);
    check("hold_win",       32'(win_a), 32'd1);
    idle_until(230);
    check("hold_rv", 32'(rv_a), 32'd1);

    // 3-candidate instance: invalid candidate, then a clean win
    do_reset();
    step(1, 0, 6'h01, 0);
    step(1, 0, 6'h02, 0);
    check("c3_nreg", 32'(nreg_b), 32'd2);
    idle_until(8);
    step(1, 1, 6'h01, 3);
    check("c3_invalid", 32'(flags_b), 32'(F_IC));
    step(1, 1, 6'h01, 1);
    check("c3_accept", 32'(flags_b), 32'd0);
    step(1, 1, 6'h01, 1);
    check("c3_revote", 32'(flags_b), 32'(F_AV));
    step(1, 1, 6'h02, 1);
    check("c3_accept2", 32'(flags_b), 32'd0);
    idle_until(19);
    check("c3_rv_19",    32'(rv_b), 32'd0);
    check("c3_phase_19", 32'(phase_b), 32'd2);
    step(0, 0, 6'h00, 0);
    check("c3_rv_20",   32'(rv_b), 32'd1);
    check("c3_win",     32'(win_b), 32'd1);
    check("c3_wcnt",    32'(wcnt_b), 32'd2);
    check("c3_tie",     32'(tie_b), 32'd0);

    // All-zero election: winner 0, count 0, tie
    do_reset();
    idle_until(19);
    check("zero_rv_19", 32'(rv_b), 32'd0);
    step(0, 0, 6'h00, 0);
    check("zero_rv",   32'(rv_b), 32'd1);
    check("zero_win",  32'(win_b), 32'd0);
    check("zero_wcnt", 32'(wcnt_b), 32'd0);
    check("zero_tie",  32'(tie_b), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
